// File: rtl/uart_frame_ctrl.sv
// Assembles a sudoku board from the UART byte stream: SOF detect, cell writes,
// XOR checksum check, then a valid/ack handoff to the solver with CTS hold.
module uart_frame_ctrl #(
   parameter int unsigned N_CELLS     = 81,
   parameter int unsigned ADDR_W      = 7,
   parameter logic [7:0]  SOF         = 8'hA5,
   parameter int unsigned MAX_VAL     = 9,
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              byte_valid,
   input  logic [7:0]        byte_in,
   output logic              cell_we,
   output logic [ADDR_W-1:0] cell_addr,
   output logic [3:0]        cell_data,
   output logic              board_valid,
   input  logic              board_ack,
   output logic              frame_err,
   output logic [1:0]        err_code,
   output logic              hold_cts,
   output logic [1:0]        state_out
);

   localparam int unsigned TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(N_CELLS - 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
   localparam logic [7:0]         MAX_BYTE   = 8'(MAX_VAL);

   localparam logic [1:0] ERR_VALUE   = 2'b01;
   localparam logic [1:0] ERR_CSUM    = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CELLS    = 2'd1,
      CSUM     = 2'd2,
      WAIT_ACK = 2'd3
   } state_t;

   state_t              state, state_n;
   logic [ADDR_W-1:0]   idx, idx_n;
   logic [7:0]          csum, csum_n;
   logic [TIMER_W-1:0]  timer, timer_n;
   logic                cell_we_n;
   logic [ADDR_W-1:0]   cell_addr_n;
   logic [3:0]          cell_data_n;
   logic                frame_err_n;
   logic [1:0]          err_code_n;
   logic                board_valid_n;
   logic                hold_cts_n;

   assign state_out = state;

   // State, frame counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         csum        <= '0;
         timer       <= '0;
         cell_we     <= 1'b0;
         cell_addr   <= '0;
         cell_data   <= '0;
         frame_err   <= 1'b0;
         err_code    <= '0;
         board_valid <= 1'b0;
         hold_cts    <= 1'b0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         csum        <= csum_n;
         timer       <= timer_n;
         cell_we     <= cell_we_n;
         cell_addr   <= cell_addr_n;
         cell_data   <= cell_data_n;
         frame_err   <= frame_err_n;
         err_code    <= err_code_n;
         board_valid <= board_valid_n;
         hold_cts    <= hold_cts_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      idx_n       = idx;
      csum_n      = csum;
      timer_n     = timer;
      cell_we_n   = 1'b0;
      cell_addr_n = cell_addr;
      cell_data_n = cell_data;
      frame_err_n = 1'b0;
      err_code_n  = err_code;

      case (state)
         IDLE: begin
            if (byte_valid && byte_in == SOF) begin
               state_n = CELLS;
               idx_n   = '0;
               csum_n  = '0;
               timer_n = '0;
            end
         end
         CELLS: begin
            if (byte_valid) begin
               timer_n = '0;
               if (byte_in <= MAX_BYTE) begin
                  cell_we_n   = 1'b1;
                  cell_addr_n = idx;
                  cell_data_n = byte_in[3:0];
                  csum_n      = csum ^ byte_in;
                  idx_n       = idx + ADDR_W'(1);
                  if (idx == LAST_IDX) state_n = CSUM;
               end else begin
                  frame_err_n = 1'b1;
                  err_code_n  = ERR_VALUE;
                  state_n     = IDLE;
               end
            end else if (timer == TIMER_LAST) begin
               frame_err_n = 1'b1;
               err_code_n  = ERR_TIMEOUT;
               state_n     = IDLE;
            end else begin
               timer_n = timer + TIMER_W'(1);
            end
         end
         CSUM: begin
            if (byte_valid) begin
               timer_n = '0;
               if (byte_in == csum) begin
                  state_n = WAIT_ACK;
               end else begin
                  frame_err_n = 1'b1;
                  err_code_n  = ERR_CSUM;
                  state_n     = IDLE;
               end
            end else if (timer == TIMER_LAST) begin
               frame_err_n = 1'b1;
               err_code_n  = ERR_TIMEOUT;
               state_n     = IDLE;
            end else begin
               timer_n = timer + TIMER_W'(1);
            end
         end
         WAIT_ACK: begin
            // Bytes arriving here break CTS and are dropped, even alongside the ack
            if (board_ack) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      board_valid_n = (state_n == WAIT_ACK);
      hold_cts_n    = (state_n == WAIT_ACK);
   end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: good/bad frames, timeout, ignored bytes
// and mid-frame reset, with a write log captured from the RAM port.
module tb_uart_frame_ctrl;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned NC     = 81;
   // Cells are i%10: each run of 0..9 XORs to 1, eight runs cancel, cell 80 is 0
   localparam logic [7:0] GOOD_CSUM = 8'h00;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              byte_valid = 1'b0;
   logic [7:0]        byte_in = 8'h00;
   logic              board_ack = 1'b0;
   logic              cell_we;
   logic [ADDR_W-1:0] cell_addr;
   logic [3:0]        cell_data;
   logic              board_valid;
   logic              frame_err;
   logic [1:0]        err_code;
   logic              hold_cts;
   logic [1:0]        state_out;

   int n_checks = 0;
   int n_pass   = 0;

   int          wr_total = 0;
   int          addr_log [0:1023];
   logic [3:0]  data_log [0:1023];

   uart_frame_ctrl #(
      .N_CELLS(NC), .ADDR_W(ADDR_W), .SOF(8'hA5), .MAX_VAL(9), .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_in(byte_in),
      .cell_we(cell_we), .cell_addr(cell_addr), .cell_data(cell_data),
      .board_valid(board_valid), .board_ack(board_ack), .frame_err(frame_err),
      .err_code(err_code), .hold_cts(hold_cts), .state_out(state_out)
   );

   always #5 clk = ~clk;

   // Log every RAM write (values launched by the previous edge)
   always @(posedge clk) begin
      if (cell_we && wr_total < 1024) begin
         addr_log[wr_total] = int'(cell_addr);
         data_log[wr_total] = cell_data;
      end
      if (cell_we) wr_total = wr_total + 1;
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_in    = b;
      @(negedge clk);
      byte_valid = 1'b0;
      byte_in    = 8'h00;
   endtask

   task automatic send_cells(input int n);
      for (int i = 0; i < n; i++) send_byte(8'(i % 10));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle(3);
      n_checks++;
      if ({cell_we, cell_addr, cell_data, board_valid, frame_err, err_code, hold_cts, state_out} !== '0)
         $display("FAIL reset_outputs: got we=%b addr=%0d data=%0d bv=%b fe=%b ec=%b cts=%b st=%0d, want all 0",
                  cell_we, cell_addr, cell_data, board_valid, frame_err, err_code, hold_cts, state_out);
      else n_pass++;
      rst_n = 1'b1;
      idle(2);
   endtask

   // Full good frame ending in WAIT_ACK, then the ack handshake
   task automatic test_good_frame(input string nm);
      int base;
      bit bad;
      base = wr_total;
      send_byte(8'hA5);
      n_checks++;
      if (state_out !== 2'd1) $display("FAIL %s_sof_state: got %0d want 1", nm, state_out);
      else n_pass++;
      send_cells(NC);
      n_checks++;
      if (state_out !== 2'd2 || board_valid !== 1'b0)
         $display("FAIL %s_csum_state: got st=%0d bv=%b want st=2 bv=0", nm, state_out, board_valid);
      else n_pass++;
      send_byte(GOOD_CSUM);
      n_checks++;
      if (board_valid !== 1'b1 || hold_cts !== 1'b1 || state_out !== 2'd3 || frame_err !== 1'b0)
         $display("FAIL %s_board_valid: got bv=%b cts=%b st=%0d fe=%b want 1 1 3 0",
                  nm, board_valid, hold_cts, state_out, frame_err);
      else n_pass++;
      idle(2);
      n_checks++;
      if (wr_total - base !== NC) $display("FAIL %s_write_count: got %0d want %0d", nm, wr_total - base, NC);
      else n_pass++;
      bad = 1'b0;
      for (int k = 0; k < int'(NC); k++)
         if (addr_log[base + k] != k || data_log[base + k] != 4'(k % 10)) bad = 1'b1;
      n_checks++;
      if (bad) $display("FAIL %s_write_seq: got out-of-order or wrong data, want addr k data k%%10", nm);
      else n_pass++;
      n_checks++;
      if (board_valid !== 1'b1 || hold_cts !== 1'b1)
         $display("FAIL %s_hold: got bv=%b cts=%b want 1 1", nm, board_valid, hold_cts);
      else n_pass++;
      board_ack = 1'b1;
      @(negedge clk);
      board_ack = 1'b0;
      n_checks++;
      if (board_valid !== 1'b0 || hold_cts !== 1'b0 || state_out !== 2'd0)
         $display("FAIL %s_ack: got bv=%b cts=%b st=%0d want 0 0 0", nm, board_valid, hold_cts, state_out);
      else n_pass++;
   endtask

   task automatic test_bad_value();
      int base;
      base = wr_total;
      send_byte(8'hA5);
      send_cells(3);
      send_byte(8'h0C);
      n_checks++;
      if (frame_err !== 1'b1 || err_code !== 2'b01 || state_out !== 2'd0)
         $display("FAIL badval_err: got fe=%b ec=%b st=%0d want 1 01 0", frame_err, err_code, state_out);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (frame_err !== 1'b0 || board_valid !== 1'b0 || err_code !== 2'b01)
         $display("FAIL badval_pulse: got fe=%b bv=%b ec=%b want 0 0 01", frame_err, board_valid, err_code);
      else n_pass++;
      idle(1);
      n_checks++;
      if (wr_total - base !== 3) $display("FAIL badval_writes: got %0d want 3", wr_total - base);
      else n_pass++;
   endtask

   task automatic test_bad_csum();
      send_byte(8'hA5);
      send_cells(NC);
      send_byte(GOOD_CSUM ^ 8'h01);
      n_checks++;
      if (frame_err !== 1'b1 || err_code !== 2'b10 || state_out !== 2'd0 || board_valid !== 1'b0)
         $display("FAIL badcsum_err: got fe=%b ec=%b st=%0d bv=%b want 1 10 0 0",
                  frame_err, err_code, state_out, board_valid);
      else n_pass++;
      idle(2);
      test_good_frame("after_badcsum");
   endtask

   task automatic test_timeout();
      int base;
      int got;
      base = wr_total;
      got  = -1;
      send_byte(8'hA5);
      send_cells(5);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (frame_err === 1'b1) begin
            got = c;
            break;
         end
      end
      n_checks++;
      if (got !== 16) $display("FAIL timeout_latency: got %0d cycles want 16", got);
      else n_pass++;
      n_checks++;
      if (err_code !== 2'b11 || state_out !== 2'd0)
         $display("FAIL timeout_code: got ec=%b st=%0d want 11 0", err_code, state_out);
      else n_pass++;
      idle(1);
      n_checks++;
      if (wr_total - base !== 5) $display("FAIL timeout_writes: got %0d want 5", wr_total - base);
      else n_pass++;
   endtask

   task automatic test_ignore();
      int base;
      base = wr_total;
      board_ack = 1'b1;
      send_byte(8'h00);
      board_ack = 1'b0;
      send_byte(8'h41);
      idle(2);
      n_checks++;
      if (wr_total - base !== 0 || state_out !== 2'd0)
         $display("FAIL junk_idle: got writes=%0d st=%0d want 0 0", wr_total - base, state_out);
      else n_pass++;
      send_byte(8'hA5);
      send_cells(NC);
      send_byte(GOOD_CSUM);
      idle(1);
      base = wr_total;
      send_byte(8'h03);
      idle(2);
      n_checks++;
      if (wr_total - base !== 0 || state_out !== 2'd3 || board_valid !== 1'b1)
         $display("FAIL byte_in_wait: got writes=%0d st=%0d bv=%b want 0 3 1",
                  wr_total - base, state_out, board_valid);
      else n_pass++;
      board_ack  = 1'b1;
      byte_valid = 1'b1;
      byte_in    = 8'hA5;
      @(negedge clk);
      board_ack  = 1'b0;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      n_checks++;
      if (state_out !== 2'd0 || board_valid !== 1'b0 || hold_cts !== 1'b0)
         $display("FAIL ack_collide: got st=%0d bv=%b cts=%b want 0 0 0", state_out, board_valid, hold_cts);
      else n_pass++;
      send_byte(8'h04);
      idle(1);
      n_checks++;
      if (state_out !== 2'd0 || wr_total - base !== 0)
         $display("FAIL sof_dropped: got st=%0d writes=%0d want 0 0", state_out, wr_total - base);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      send_byte(8'hA5);
      send_cells(40);
      n_checks++;
      if (state_out !== 2'd1) $display("FAIL mid_state: got %0d want 1", state_out);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({cell_we, cell_addr, cell_data, board_valid, frame_err, err_code, hold_cts, state_out} !== '0)
         $display("FAIL mid_reset: got we=%b addr=%0d data=%0d bv=%b fe=%b ec=%b cts=%b st=%0d, want all 0",
                  cell_we, cell_addr, cell_data, board_valid, frame_err, err_code, hold_cts, state_out);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      test_good_frame("after_reset");
   endtask

   initial begin
      test_reset();
      test_good_frame("good");
      idle(2);
      test_bad_value();
      test_bad_csum();
      idle(2);
      test_timeout();
      test_ignore();
      idle(2);
      test_reset_mid();
      idle(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
